// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard sequencer: hazard
// sources flow in, pipeline-register enables/flushes and perf counters flow out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_to_reg;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             dmem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    // Datapath side: supplies hazard information, consumes the controls.
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_to_reg,
               ex_branch_taken, mem_req, dmem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_flush, mem_err, stall_cycles, flush_events
    );

    // Sequencer side.
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_to_reg,
               ex_branch_taken, mem_req, dmem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_flush, mem_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubble, branch
// redirect flush, data-memory freeze with timeout, and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input logic             clk,
    input logic             reset_n,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic freeze;
    logic run_rules;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;

    assign load_use = hz.ex_mem_to_reg && (hz.ex_rd != 5'd0) &&
                      ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        freeze      = 1'b0;
        run_rules   = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;

        case (state_q)
            RUN: begin
                if (hz.mem_req && !hz.dmem_ready) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!hz.dmem_ready) begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WAIT_LAST) state_d = ERR;
                end else begin
                    // Release cycle: instructions held in EX/ID are judged as usual.
                    run_rules = 1'b1;
                    state_d   = RUN;
                end
            end
            ERR:     freeze  = 1'b1;
            default: state_d = RUN;
        endcase

        if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (run_rules && hz.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (run_rules && load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end

        // Hold every pipeline register in bubble while reset is asserted.
        if (!reset_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (ifid_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_en      = idex_en;
    assign hz.idex_flush   = idex_flush;
    assign hz.exmem_en     = exmem_en;
    assign hz.memwb_flush  = memwb_flush;
    assign hz.mem_err      = (state_q == ERR);
    assign hz.stall_cycles = stall_cnt_q;
    assign hz.flush_events = flush_cnt_q;

endmodule
